// File: rtl/network_loader.sv
// network_loader: parses A5/LEN/payload frames from a byte stream into little-endian BRAM word writes.
// Define NETWORK_LOADER_CHECKSUM_EN to require a trailing XOR byte over the payload.
module network_loader #(
   parameter int ADDR_LEN  = 2**16,
   parameter int DATA_LEN  = 32,
   parameter int BASE_ADDR = 0
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic [7:0]                  byte_i,
   input  logic                        byte_valid_i,
   output logic                        byte_ready_o,
   output logic                        wr_ena_o,
   output logic [$clog2(ADDR_LEN)-1:0] wr_addr_o,
   output logic [DATA_LEN-1:0]         wr_data_o,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        error_o,
   output logic [15:0]                 word_count_o
);
   localparam int AW      = $clog2(ADDR_LEN);
   localparam int NBYTES  = DATA_LEN / 8;
   localparam int BW      = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam int MAX_LEN = ADDR_LEN - BASE_ADDR;
   localparam logic [7:0] SYNC = 8'hA5;

   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, PAYLOAD, CHECK, DONE} state_t;

   state_t              state;
   logic [7:0]          len_lo;
   logic [15:0]         len;
   logic [15:0]         len_rx;
   logic [BW-1:0]       byte_idx;
   logic [DATA_LEN-1:0] word_q;
   logic [DATA_LEN-1:0] word_nxt;
   logic                take;
   logic                last_byte;
   logic                last_word;
`ifdef NETWORK_LOADER_CHECKSUM_EN
   logic [7:0]          csum;
`endif

   assign take      = byte_valid_i && byte_ready_o;
   assign last_byte = (byte_idx == BW'(NBYTES - 1));
   assign last_word = (word_count_o == len - 16'd1);
   assign len_rx    = {byte_i, len_lo};

   // Incoming byte merged into its lane so the final byte can be written without a bubble.
   always_comb begin
      word_nxt = word_q;
      word_nxt[byte_idx*8 +: 8] = byte_i;
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state        <= IDLE;
         byte_ready_o <= 1'b0;
         wr_ena_o     <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
         word_count_o <= '0;
         len_lo       <= '0;
         len          <= '0;
         byte_idx     <= '0;
         word_q       <= '0;
`ifdef NETWORK_LOADER_CHECKSUM_EN
         csum         <= '0;
`endif
      end else begin
         byte_ready_o <= 1'b1;
         wr_ena_o     <= 1'b0;
         done_o       <= 1'b0;
         case (state)
            IDLE: if (take && byte_i == SYNC) begin
               state        <= LEN_LO;
               busy_o       <= 1'b1;
               error_o      <= 1'b0;
               word_count_o <= '0;
               byte_idx     <= '0;
`ifdef NETWORK_LOADER_CHECKSUM_EN
               csum         <= '0;
`endif
            end
            LEN_LO: if (take) begin
               len_lo <= byte_i;
               state  <= LEN_HI;
            end
            LEN_HI: if (take) begin
               len <= len_rx;
               // Bounds check keeps BASE_ADDR + word index from wrapping the address.
               if (len_rx == 16'd0 || int'(len_rx) > MAX_LEN) begin
                  error_o <= 1'b1;
                  busy_o  <= 1'b0;
                  state   <= IDLE;
               end else begin
                  state <= PAYLOAD;
               end
            end
            PAYLOAD: if (take) begin
               word_q <= word_nxt;
`ifdef NETWORK_LOADER_CHECKSUM_EN
               csum   <= csum ^ byte_i;
`endif
               if (last_byte) begin
                  byte_idx     <= '0;
                  wr_ena_o     <= 1'b1;
                  wr_addr_o    <= AW'(BASE_ADDR) + AW'(word_count_o);
                  wr_data_o    <= word_nxt;
                  word_count_o <= word_count_o + 16'd1;
                  if (last_word) begin
                     byte_ready_o <= 1'b0;
`ifdef NETWORK_LOADER_CHECKSUM_EN
                     state        <= CHECK;
`else
                     state        <= DONE;
`endif
                  end
               end else begin
                  byte_idx <= byte_idx + BW'(1);
               end
            end
`ifdef NETWORK_LOADER_CHECKSUM_EN
            CHECK: if (take) begin
               busy_o <= 1'b0;
               state  <= IDLE;
               if (byte_i == csum) begin
                  done_o       <= 1'b1;
                  byte_ready_o <= 1'b0;
               end else begin
                  error_o <= 1'b1;
               end
            end
`endif
            DONE: begin
               done_o       <= 1'b1;
               busy_o       <= 1'b0;
               byte_ready_o <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_network_loader.sv
// Directed bench for network_loader: default-parameter instance plus a BASE_ADDR=16, ADDR_LEN=32 instance.
module tb_network_loader;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel = 1'b0;
   logic       vld = 1'b0;
   logic [7:0] bt = 8'h00;

   logic        rdy1, wr1, busy1, done1, err1;
   logic [15:0] addr1, wc1;
   logic [31:0] data1;
   logic        rdy2, wr2, busy2, done2, err2;
   logic [4:0]  addr2;
   logic [15:0] wc2;
   logic [31:0] data2;

   int checks = 0;
   int errors = 0;
   int nw1 = 0, nd1 = 0, nw2 = 0, nd2 = 0;
   logic [15:0] wa1 [0:63];
   logic [31:0] wd1 [0:63];
   logic [4:0]  wa2 [0:63];
   logic [31:0] wd2 [0:63];
   int bw, bd;

   always #5 clk = ~clk;

   network_loader dut1 (
      .clk_i(clk), .reset_i(rst_n), .byte_i(bt), .byte_valid_i(vld && !sel),
      .byte_ready_o(rdy1), .wr_ena_o(wr1), .wr_addr_o(addr1), .wr_data_o(data1),
      .busy_o(busy1), .done_o(done1), .error_o(err1), .word_count_o(wc1)
   );

   network_loader #(.ADDR_LEN(32), .DATA_LEN(32), .BASE_ADDR(16)) dut2 (
      .clk_i(clk), .reset_i(rst_n), .byte_i(bt), .byte_valid_i(vld && sel),
      .byte_ready_o(rdy2), .wr_ena_o(wr2), .wr_addr_o(addr2), .wr_data_o(data2),
      .busy_o(busy2), .done_o(done2), .error_o(err2), .word_count_o(wc2)
   );

   always @(negedge clk) begin
      if (wr1) begin wa1[nw1 % 64] = addr1; wd1[nw1 % 64] = data1; nw1++; end
      if (done1) nd1++;
      if (wr2) begin wa2[nw2 % 64] = addr2; wd2[nw2 % 64] = data2; nw2++; end
      if (done2) nd2++;
   end

   function automatic logic cur_rdy();  return sel ? rdy2  : rdy1;  endfunction
   function automatic logic cur_wr();   return sel ? wr2   : wr1;   endfunction
   function automatic logic cur_done(); return sel ? done2 : done1; endfunction
   function automatic logic cur_busy(); return sel ? busy2 : busy1; endfunction
   function automatic logic cur_err();  return sel ? err2  : err1;  endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      bt = b;
      vld = 1'b1;
      while (!cur_rdy() && n < 20) begin @(negedge clk); n++; end
      assert (n < 20) else begin
         errors++;
         $error("FAIL ready_timeout: observed %0d cycles expected under 20", n);
      end
      @(negedge clk);
   endtask

   task automatic send_hdr(input logic [15:0] len);
      send(8'hA5); send(len[7:0]); send(len[15:8]);
   endtask

   task automatic send_word(input logic [31:0] w);
      send(w[7:0]); send(w[15:8]); send(w[23:16]); send(w[31:24]);
   endtask

   task automatic idle(input int n);
      vld = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Entered one cycle after the last payload byte was accepted.
   task automatic tail(input logic [7:0] ck, input logic pass);
      vld = 1'b0;
      chk("wr_last", cur_wr(), 1);
      chk("rdy_at_write", cur_rdy(), 0);
      chk("done_early", cur_done(), 0);
`ifdef NETWORK_LOADER_CHECKSUM_EN
      send(ck);
      vld = 1'b0;
      chk("done_ck", cur_done(), pass);
      chk("err_ck", cur_err(), !pass);
      chk("busy_ck", cur_busy(), 0);
      chk("rdy_ck", cur_rdy(), !pass);
      @(negedge clk);
      chk("done_pulse", cur_done(), 0);
      chk("rdy_back", cur_rdy(), 1);
`else
      $display("frame tail without trailer (payload xor %02h)", ck);
      @(negedge clk);
      chk("done", cur_done(), pass);
      chk("busy_end", cur_busy(), 0);
      chk("rdy_done", cur_rdy(), 0);
      chk("wr_after", cur_wr(), 0);
      @(negedge clk);
      chk("done_pulse", cur_done(), 0);
      chk("rdy_back", cur_rdy(), 1);
`endif
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_rdy", rdy1, 0);
      chk("rst_wr", wr1, 0);
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_err", err1, 0);
      chk("rst_wc", wc1, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", rdy1, 1);

      // Back-to-back two-word frame
      bw = nw1; bd = nd1;
      send_hdr(16'd2);
      chk("busy_frame", busy1, 1);
      send_word(32'h3);
      send_word(32'h2);
      tail(8'h01, 1'b1);
      chk("f1_nwr", nw1 - bw, 2);
      chk("f1_a0", wa1[bw % 64], 0);
      chk("f1_d0", wd1[bw % 64], 32'h3);
      chk("f1_a1", wa1[(bw + 1) % 64], 1);
      chk("f1_d1", wd1[(bw + 1) % 64], 32'h2);
      chk("f1_wc", wc1, 2);
      chk("f1_done", nd1 - bd, 1);
      chk("f1_err", err1, 0);

      // Garbage before sync, valid gap mid-word
      idle(2);
      bw = nw1; bd = nd1;
      send(8'h11); send(8'h22);
      chk("garbage_busy", busy1, 0);
      send_hdr(16'd2);
      send(8'h03); send(8'h00);
      idle(3);
      send(8'h00); send(8'h00);
      send_word(32'h2);
      tail(8'h01, 1'b1);
      chk("f2_nwr", nw1 - bw, 2);
      chk("f2_a0", wa1[bw % 64], 0);
      chk("f2_d0", wd1[bw % 64], 32'h3);
      chk("f2_a1", wa1[(bw + 1) % 64], 1);
      chk("f2_d1", wd1[(bw + 1) % 64], 32'h2);
      chk("f2_done", nd1 - bd, 1);

      // LEN == 0, then a fresh sync clears the error
      idle(2);
      bw = nw1; bd = nd1;
      send_hdr(16'd0);
      vld = 1'b0;
      chk("len0_err", err1, 1);
      chk("len0_busy", busy1, 0);
      idle(3);
      chk("len0_nwr", nw1 - bw, 0);
      chk("len0_done", nd1 - bd, 0);
      send(8'hA5);
      chk("sync_clr_err", err1, 0);
      chk("sync_busy", busy1, 1);
      send(8'h01); send(8'h00);
      send_word(32'h11223344);
      tail(8'h44, 1'b1);
      chk("f3_nwr", nw1 - bw, 1);
      chk("f3_a0", wa1[bw % 64], 0);
      chk("f3_d0", wd1[bw % 64], 32'h11223344);
      chk("f3_wc", wc1, 1);

`ifdef NETWORK_LOADER_CHECKSUM_EN
      // Wrong checksum: words stay written, no done
      idle(2);
      bw = nw1; bd = nd1;
      send_hdr(16'd2);
      send_word(32'h3);
      send_word(32'h2);
      tail(8'hFF, 1'b0);
      chk("bad_ck_nwr", nw1 - bw, 2);
      chk("bad_ck_done", nd1 - bd, 0);
      chk("bad_ck_wc", wc1, 2);
`endif

      // Reset after five payload bytes
      idle(2);
      bw = nw1; bd = nd1;
      send_hdr(16'd2);
      send_word(32'h3);
      send(8'h02);
      vld = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_wc", wc1, 0);
      chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_wr", wr1, 0);
      chk("mid_rst_rdy", rdy1, 0);
      idle(3);
      chk("mid_rst_nwr", nw1 - bw, 1);
      bw = nw1; bd = nd1;
      send_hdr(16'd2);
      send_word(32'hDEADBEEF);
      send_word(32'h5);
      tail(8'h27, 1'b1);
      chk("f4_nwr", nw1 - bw, 2);
      chk("f4_a0", wa1[bw % 64], 0);
      chk("f4_d0", wd1[bw % 64], 32'hDEADBEEF);
      chk("f4_a1", wa1[(bw + 1) % 64], 1);
      chk("f4_d1", wd1[(bw + 1) % 64], 32'h5);
      chk("f4_done", nd1 - bd, 1);

      // BASE_ADDR=16 instance: over-length frame, then single-word frame
      idle(2);
      sel = 1'b1;
      bw = nw2; bd = nd2;
      send_hdr(16'd17);
      vld = 1'b0;
      chk("b16_len_err", err2, 1);
      chk("b16_len_busy", busy2, 0);
      idle(2);
      chk("b16_len_nwr", nw2 - bw, 0);
      send_hdr(16'd1);
      chk("b16_err_clr", err2, 0);
      send_word(32'h11223344);
      tail(8'h44, 1'b1);
      chk("b16_nwr", nw2 - bw, 1);
      chk("b16_a0", wa2[bw % 64], 16);
      chk("b16_d0", wd2[bw % 64], 32'h11223344);
      chk("b16_wc", wc2, 1);
      chk("b16_done", nd2 - bd, 1);
      chk("dut1_quiet", nw1 - bw >= 0 ? rdy1 : 1'b0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
